// File: rtl/cpu_pkg.sv
// Shared CPU-side types and constants used by the fetch stage and its bench.
package cpu_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 5;

    // addi x0, x0, 0 -- what decode sees when fetch has nothing to offer
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response plus decode-facing head and control.
interface fetch_unit_if #(
    parameter int INSTR_WIDTH = 32,
    parameter int PC_WIDTH    = 5
);

    logic                   i_stall;
    logic                   i_redirect;
    logic [PC_WIDTH-1:0]    i_redirect_pc;
    logic                   o_imem_req;
    logic [PC_WIDTH-1:0]    o_imem_addr;
    logic                   i_imem_valid;
    logic [INSTR_WIDTH-1:0] i_imem_data;
    logic [INSTR_WIDTH-1:0] o_instruction;
    logic [PC_WIDTH-1:0]    o_pc;
    logic                   o_valid;

    modport master (
        input  i_stall, i_redirect, i_redirect_pc, i_imem_valid, i_imem_data,
        output o_imem_req, o_imem_addr, o_instruction, o_pc, o_valid
    );

    modport slave (
        output i_stall, i_redirect, i_redirect_pc, i_imem_valid, i_imem_data,
        input  o_imem_req, o_imem_addr, o_instruction, o_pc, o_valid
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with clear; head is read combinationally from registered storage.
module fetch_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic [31:0]
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         push,
    input  T                             push_data,
    input  logic                         pop,
    output T                             head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC generation, credit-limited in-order memory reads, response buffering
// and wrong-path squashing on branch redirect.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                   INSTR_WIDTH = 32,
    parameter int                   PC_WIDTH    = 5,
    parameter int                   FIFO_DEPTH  = 2,
    parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    localparam int             CW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);

    typedef struct packed {
        logic [PC_WIDTH-1:0]    pc;
        logic [INSTR_WIDTH-1:0] instr;
    } entry_t;

    logic [PC_WIDTH-1:0] fetch_pc;
    logic [CW-1:0]       inflight;
    logic [CW-1:0]       kill;
    logic [CW-1:0]       buf_count;
    logic [CW-1:0]       tag_count;
    logic                buf_full;
    logic                buf_empty;
    logic                tag_full;
    logic                tag_empty;
    entry_t              buf_head;
    entry_t              buf_push_data;
    logic [PC_WIDTH-1:0] tag_head;
    logic                issue;
    logic                pop_fire;
    logic                resp_live;
    logic                resp_kill;
    logic [CW:0]         credit_used;
    logic [CW:0]         credit_limit;

    // A slot freed by this cycle's pop may be re-granted at once, so a 2-deep
    // buffer sustains one instruction per cycle with single-cycle memory.
    assign pop_fire     = !buf_empty && !bus.i_stall && !bus.i_redirect;
    assign credit_used  = {1'b0, buf_count} + {1'b0, inflight};
    assign credit_limit = (CW+1)'(FIFO_DEPTH) + {{CW{1'b0}}, pop_fire};
    assign issue        = !rst && !bus.i_redirect && (credit_used < credit_limit);

    assign resp_kill    = bus.i_imem_valid && (kill != '0);
    assign resp_live    = bus.i_imem_valid && (kill == '0) && !bus.i_redirect;

    assign buf_push_data.pc    = tag_head;
    assign buf_push_data.instr = bus.i_imem_data;

    assign bus.o_imem_req    = issue;
    assign bus.o_imem_addr   = fetch_pc;
    assign bus.o_valid       = !buf_empty;
    assign bus.o_instruction = buf_empty ? INSTR_WIDTH'(NOP_INSTR) : buf_head.instr;
    assign bus.o_pc          = buf_empty ? '0 : buf_head.pc;

    // PCs of live in-flight requests; squashed requests are tracked only by kill
    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (logic [PC_WIDTH-1:0])
    ) u_tag_q (
        .clk       (clk),
        .rst       (rst),
        .clear     (bus.i_redirect),
        .push      (issue),
        .push_data (fetch_pc),
        .pop       (resp_live),
        .head      (tag_head),
        .count     (tag_count),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (entry_t)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .clear     (bus.i_redirect),
        .push      (resp_live),
        .push_data (buf_push_data),
        .pop       (pop_fire),
        .head      (buf_head),
        .count     (buf_count),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            inflight <= '0;
            kill     <= '0;
        end else begin
            inflight <= inflight + CW'(issue) - CW'(bus.i_imem_valid);
            if (bus.i_redirect) begin
                fetch_pc <= bus.i_redirect_pc;
                // everything still outstanding is wrong-path, including earlier squashes
                kill     <= inflight - CW'(bus.i_imem_valid);
            end else begin
                if (issue)     fetch_pc <= fetch_pc + PC_WIDTH'(1);
                if (resp_kill) kill     <= kill - CW'(1);
            end
        end
    end

    a_counters_bounded: assert property (@(posedge clk) disable iff (rst)
        buf_count <= DEPTH_C && inflight <= DEPTH_C && kill <= DEPTH_C);
    a_kill_le_inflight: assert property (@(posedge clk) disable iff (rst)
        kill <= inflight);
    a_tags_consistent: assert property (@(posedge clk) disable iff (rst)
        tag_count + kill == inflight);
    a_live_resp_has_tag: assert property (@(posedge clk) disable iff (rst)
        !(bus.i_imem_valid && kill == '0 && tag_empty));
    a_no_tag_overflow: assert property (@(posedge clk) disable iff (rst)
        !(issue && tag_full && !resp_live));
    a_no_buf_overflow: assert property (@(posedge clk) disable iff (rst)
        !(resp_live && buf_full && !pop_fire));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: latency-programmable memory model plus a scoreboard of
// expected {pc, instr} pushed when a live response is driven and popped on DUT pop.
module tb_fetch_unit;
    import cpu_pkg::*;

    localparam int DEPTH = 2;

    typedef struct {
        logic [4:0] addr;
        int         due;
        int         epoch;
    } mreq_t;

    typedef struct {
        logic [4:0]  pc;
        logic [31:0] instr;
        int          pcyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_unit_if #(.INSTR_WIDTH(32), .PC_WIDTH(5)) bus ();

    fetch_unit #(
        .INSTR_WIDTH (32),
        .PC_WIDTH    (5),
        .FIFO_DEPTH  (DEPTH),
        .RESET_PC    (5'h00)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mreq_t       mq[$];
    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          lat = 1;
    int          epoch = 0;
    logic [4:0]  req_pc = 5'h00;
    logic        last_req;
    logic [4:0]  last_addr;
    logic        last_valid;
    logic [4:0]  last_pc;
    logic [31:0] last_instr;

    function automatic logic [31:0] word(input logic [4:0] a);
        return {16'hC0DE, 3'b000, a, 8'h5A};
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic cycle(input logic stall, input logic redir, input logic [4:0] rpc);
        mreq_t m;
        exp_t  e;
        @(negedge clk);
        rst               = 1'b0;
        bus.i_stall       = stall;
        bus.i_redirect    = redir;
        bus.i_redirect_pc = rpc;
        bus.i_imem_valid  = 1'b0;
        bus.i_imem_data   = '0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            m = mq.pop_front();
            bus.i_imem_valid = 1'b1;
            bus.i_imem_data  = word(m.addr);
            if (m.epoch == epoch && !redir) exp_q.push_back('{m.addr, word(m.addr), cyc});
        end
        if (redir) begin
            epoch++;
            exp_q.delete();
            req_pc = rpc;
        end
        #1;
        last_req   = bus.o_imem_req;
        last_addr  = bus.o_imem_addr;
        last_valid = bus.o_valid;
        last_pc    = bus.o_pc;
        last_instr = bus.o_instruction;
        if (redir) check_val("req_on_redirect", bus.o_imem_req, 0);
        if (bus.o_imem_req) begin
            check_val("req_addr", bus.o_imem_addr, req_pc);
            mq.push_back('{bus.o_imem_addr, cyc + lat, epoch});
            req_pc = req_pc + 5'd1;
            check_val("inflight_bound", mq.size() <= DEPTH, 1);
        end
        if (!bus.o_valid) begin
            check_val("empty_instr", bus.o_instruction, NOP_INSTR);
            check_val("empty_pc", bus.o_pc, 0);
            if (exp_q.size() > 0 && exp_q[0].pcyc < cyc) check_val("head_missing", bus.o_valid, 1);
        end else if (!stall && !redir) begin
            if (exp_q.size() == 0) begin
                check_val("sb_underflow", bus.o_valid, 0);
            end else begin
                e = exp_q.pop_front();
                check_val("head_pc", bus.o_pc, e.pc);
                check_val("head_instr", bus.o_instruction, e.instr);
            end
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 5'h00);
    endtask

    task automatic wait_valid(input string tag, input logic [4:0] exp_pc);
        int n;
        n = 0;
        do begin
            cycle(1'b0, 1'b0, 5'h00);
            n++;
        end while (!last_valid && n < 30);
        check_val(tag, {last_valid, last_pc}, {1'b1, exp_pc});
    endtask

    initial begin
        logic       vhist[6];
        logic [4:0] frz_pc;
        logic [31:0] frz_instr;
        int         stall_reqs;
        int         n;
        logic       seen_wrap;
        logic [4:0] prev_addr;

        rst               = 1'b1;
        bus.i_stall       = 1'b0;
        bus.i_redirect    = 1'b0;
        bus.i_redirect_pc = '0;
        bus.i_imem_valid  = 1'b0;
        bus.i_imem_data   = '0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            check_val("rst_req", bus.o_imem_req, 0);
            check_val("rst_valid", bus.o_valid, 0);
            check_val("rst_instr", bus.o_instruction, NOP_INSTR);
            check_val("rst_pc", bus.o_pc, 0);
        end

        // single-cycle memory: request at cycle 0, first head at cycle 2, then one per cycle
        lat = 1;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b0, 5'h00);
            vhist[i] = last_valid;
        end
        check_val("l1_valid_c0", vhist[0], 0);
        check_val("l1_valid_c1", vhist[1], 0);
        for (int i = 2; i < 6; i++) check_val("l1_valid_stream", vhist[i], 1);

        lat = 3;
        run(20);

        // stall: head frozen, issue stops once credits are used up
        lat = 1;
        run(6);
        stall_reqs = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 5'h00);
            stall_reqs += int'(last_req);
            if (i == 0) begin
                check_val("stall_head_valid", last_valid, 1);
                frz_pc    = last_pc;
                frz_instr = last_instr;
            end else begin
                check_val("stall_pc_frozen", last_pc, frz_pc);
                check_val("stall_instr_frozen", last_instr, frz_instr);
            end
        end
        check_val("stall_req_bound", stall_reqs <= DEPTH, 1);
        check_val("stall_req_dropped", last_req, 0);
        cycle(1'b0, 1'b0, 5'h00);
        check_val("resume_req", last_req, 1);
        run(5);

        // redirect with two reads outstanding
        lat = 3;
        n = 0;
        while (mq.size() != 2 && n < 10) begin
            cycle(1'b0, 1'b0, 5'h00);
            n++;
        end
        check_val("wait_two_inflight", mq.size(), 2);
        cycle(1'b0, 1'b1, 5'h10);
        wait_valid("redirect_target_10", 5'h10);
        run(6);

        // redirect and stall in the same cycle
        lat = 2;
        run(4);
        cycle(1'b1, 1'b1, 5'h08);
        wait_valid("redirect_stall_target", 5'h08);
        run(4);

        // redirect while a response lands, then a second redirect while still squashing
        n = 0;
        while (!(mq.size() > 0 && mq[0].due <= cyc) && n < 10) begin
            cycle(1'b0, 1'b0, 5'h00);
            n++;
        end
        check_val("wait_resp_due", mq.size() > 0, 1);
        cycle(1'b0, 1'b1, 5'h18);
        cycle(1'b0, 1'b1, 5'h0C);
        wait_valid("double_redirect_target", 5'h0C);
        run(6);

        // PC wrap 1F -> 00
        lat = 1;
        cycle(1'b0, 1'b1, 5'h1E);
        seen_wrap = 1'b0;
        prev_addr = 5'h00;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b0, 5'h00);
            if (last_req) begin
                if (prev_addr == 5'h1F && last_addr == 5'h00) seen_wrap = 1'b1;
                prev_addr = last_addr;
            end
        end
        check_val("pc_wrap_seen", seen_wrap, 1);
        run(8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
